file_register: RTL and testbench
================================

Name: file_register

Overview:
- Small synchronous-write, asynchronous-read register file: 8 entries of 8 bits, one write port and one read port sharing a single address.
- Sits in the single-cycle processor datapath as the general-purpose register bank.
- The addressed entry is continuously presented on the output.
- All entries clear asynchronously on reset.

Parameters:
- DATA_W, 8, width of each register and of d_in/q_out.
- ADDR_W, 3, address width.
- DEPTH, 2**ADDR_W (8), number of registers; all addresses are valid.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  asynchronous, active-low reset: 0 clears every register immediately; 1 is normal operation.
- load  input  1  write enable; sampled on rising clk edge.
- address  input  ADDR_W  selects the register written (when load=1) and the register read.
- d_in  input  DATA_W  write data.
- q_out  output  DATA_W  contents of the register selected by address.

Behaviour:
- Storage: DEPTH x DATA_W flops, regs[0..DEPTH-1]. No hardwired-zero entry; register 0 is writable like the others.
- Reset:
  - reset=0 forces all regs to 0 at once, independent of clk, load, address and d_in. q_out therefore reads 0 for any address.
  - While reset=0, no writes occur.
  - Deassertion (0->1) is expected synchronous to clk from upstream logic; the first write may occur on the first rising edge with reset=1.
- Write:
  - On rising clk with reset=1 and load=1: regs[address] <= d_in.
  - Only the addressed entry changes; all other entries hold.
- Hold: load=0 means no entry changes, regardless of d_in or address activity.
- Read:
  - Combinational: q_out = regs[address] with zero latency.
  - Changing address changes q_out in the same cycle without a clock edge.
- Read-during-write:
  - q_out shows the old value until the rising edge.
  - After the edge it shows d_in (write-first visibility one edge later, no bypass).
- Timing of enable: load and address are both sampled at the same edge. If address changes between edges while load stays 1, only the address present at each edge is written.
- Widths: no arithmetic. d_in is stored verbatim and address is used unmodified (full decode, no wrap needed).
- Reset mid-operation: an asynchronous assert during a cycle with load=1 suppresses the pending write, and all entries read 0.
- No X propagation: after reset every entry is defined.

Decomposition:
- Shared package (file_register_pkg): DATA_W, ADDR_W, DEPTH constants and a data word typedef (logic [DATA_W-1:0]), reused by the datapath and ALU.
- One natural sub-module, reg_cell: a single DATA_W register with clk, reset (async active-low), enable, d and q.
- The top instantiates DEPTH reg_cells via a generate loop, drives each enable from a one-hot write-address decoder gated by load, and drives q_out from a DEPTH:1 read mux on address.

Test Plan:
- Reset: write nonzero values, then pull reset low mid-cycle (between clk edges) -> q_out becomes 0x00 immediately for every address swept while reset=0; entries remain 0x00 after release.
- Fill: for i=0..7 write address=i, d_in=0xAA+i with load=1 for one edge, then load=0 -> reading addr i returns 0xAA+i (0xAA..0xB1); the other entries are unchanged.
- Hold: load=0 while d_in is toggled to 0xCC for 8 cycles and address is swept -> every entry still holds 0xAA+i.
- Sweep write: address stepped 0..7 each cycle with load=1 and d_in=0xCC -> after the final edge all 8 entries read 0xCC; confirm the entry is unchanged before its edge.
- Read-during-write: address=3 holding 0xAD, load=1, d_in=0x5A -> q_out=0xAD before the edge and 0x5A after it; address 4 is unaffected.
- Reset while load=1: reset low with load=1 and d_in=0xFF -> no entry becomes 0xFF, and all entries read 0x00.

Source files
------------

// File: rtl/file_register_pkg.sv
// Shared constants and word type for the register bank, datapath and ALU.
package file_register_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage : file_register_pkg

// File: rtl/reg_cell.sv
// One DATA_W-wide storage register: loads d on a rising clk when enabled,
// clears asynchronously while reset is low.
module reg_cell
    import file_register_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage flop with async clear; reset also blocks any pending load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (enable)
            q <= d;
    end

endmodule : reg_cell

// File: rtl/file_register.sv
// General-purpose register bank: DEPTH x DATA_W, one synchronous write port
// and one combinational read port sharing the same address.
module file_register
    import file_register_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [ADDR_W_P-1:0] address,
    input  logic [DATA_W_P-1:0] d_in,
    output logic [DATA_W_P-1:0] q_out
);

    localparam int NREG = 2 ** ADDR_W_P;

    logic [NREG-1:0]               wr_en;
    logic [NREG-1:0][DATA_W_P-1:0] regs;

    // One-hot write decode, gated by load so nothing changes when idle.
    always_comb begin
        wr_en = '0;
        if (load)
            wr_en[address] = 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_reg
            reg_cell #(.W(DATA_W_P)) u_cell (
                .clk    (clk),
                .reset  (reset),
                .enable (wr_en[i]),
                .d      (d_in),
                .q      (regs[i])
            );
        end
    endgenerate

    // Zero-latency read; a same-cycle write becomes visible after the edge.
    assign q_out = regs[address];

endmodule : file_register

// File: tb/tb_file_register.sv
// Directed bench for file_register: a vector table covers fill, hold, sweep
// and read-during-write; hand-written sequences cover the reset corners.
module tb_file_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [2:0] address;
    logic [7:0] d_in;
    logic [7:0] q_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       ld;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] pre;   // q_out expected before the rising edge
        logic [7:0] post;  // q_out expected after the rising edge
    } vec_t;

    vec_t vecs[$];

    file_register dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .d_in    (d_in),
        .q_out   (q_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input logic [2:0] a,
                                input logic [7:0] d, input logic [7:0] pre,
                                input logic [7:0] post);
        vec_t v;
        v.ld = ld; v.a = a; v.d = d; v.pre = pre; v.post = post;
        vecs.push_back(v);
    endfunction

    initial begin
        // Fill: each entry starts at 0 and takes 0xAA+i after its edge.
        for (int i = 0; i < 8; i++)
            add(1'b1, 3'(i), 8'(8'hAA + i), 8'h00, 8'(8'hAA + i));
        // Hold: load=0 with d_in=0xCC, sweep addresses.
        for (int i = 0; i < 8; i++)
            add(1'b0, 3'(i), 8'hCC, 8'(8'hAA + i), 8'(8'hAA + i));
        // Read-during-write on entry 3, then neighbour 4 untouched.
        add(1'b1, 3'd3, 8'h5A, 8'hAD, 8'h5A);
        add(1'b0, 3'd4, 8'h00, 8'hAE, 8'hAE);
        // Sweep write 0xCC; each entry shows its old value before its edge.
        for (int i = 0; i < 8; i++)
            add(1'b1, 3'(i), 8'hCC, (i == 3) ? 8'h5A : 8'(8'hAA + i), 8'hCC);
        // Readback after sweep.
        for (int i = 0; i < 8; i++)
            add(1'b0, 3'(i), 8'h33, 8'hCC, 8'hCC);

        // Reset held low with an active write request: nothing is stored.
        reset = 1'b0; load = 1'b1; address = 3'd0; d_in = 8'hFF;
        #1;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            @(posedge clk); #1;
            chk("reset_init", q_out, 8'h00);
        end
        @(negedge clk);
        reset = 1'b1; load = 1'b0;

        // Table.
        foreach (vecs[k]) begin
            @(negedge clk);
            load = vecs[k].ld; address = vecs[k].a; d_in = vecs[k].d;
            #1 chk($sformatf("vec%0d_pre", k), q_out, vecs[k].pre);
            @(posedge clk);
            #1 chk($sformatf("vec%0d_post", k), q_out, vecs[k].post);
        end

        // Address change alone moves q_out with no clock edge.
        @(negedge clk);
        load = 1'b0; d_in = 8'h00;
        address = 3'd1; #1 chk("comb_read_a1", q_out, 8'hCC);

        // Mid-cycle reset assert while a write of 0xFF is pending.
        @(negedge clk);
        load = 1'b1; address = 3'd5; d_in = 8'hFF;
        #2 reset = 1'b0;
        #1 chk("rst_async_a5", q_out, 8'h00);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #0.5 chk($sformatf("rst_sweep_a%0d", a), q_out, 8'h00);
        end
        address = 3'd5;
        @(posedge clk); #1 chk("rst_no_write", q_out, 8'h00);

        // Release; entries stay cleared.
        @(negedge clk);
        reset = 1'b1; load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1 chk($sformatf("post_rst_a%0d", a), q_out, 8'h00);
        end

        // First edge after release accepts a write, including entry 0.
        @(negedge clk);
        load = 1'b1; address = 3'd0; d_in = 8'h81;
        @(posedge clk); #1 chk("first_write_a0", q_out, 8'h81);
        @(negedge clk);
        load = 1'b0; address = 3'd7;
        #1 chk("first_write_a7_clear", q_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_file_register
